// File: rtl/ex_stage.sv
// Execute stage: integer ALU, effective-address generation and an optional
// iterative HI/LO multiply/divide unit, enabled by defining EX_STAGE_MULDIV_EN.
//
// state    | meaning
// IDLE     | no HI/LO operation in flight; mfhi/mflo/mthi/mtlo/mult/div accepted
// BUSY_MUL | 32 shift-add iterations on operand magnitudes
// BUSY_DIV | 32 restoring-division iterations on operand magnitudes
module ex_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic [4:0]  shamt,
  input  logic [15:0] imm,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic [4:0]  rd,
  input  logic        register_write,
  output logic [5:0]  opcode_o,
  output logic [4:0]  rd_o,
  output logic        register_write_o,
  output logic [31:0] result_o,
  output logic [31:0] address_o,
  output logic        stall_o
);

  logic [31:0] sext_imm;
  logic [31:0] zext_imm;
  logic [31:0] alu_res;
  logic [31:0] addr_res;
  logic        rw_next;
  logic        is_mem;

  assign sext_imm = {{16{imm[15]}}, imm};
  assign zext_imm = {16'h0000, imm};
  assign is_mem   = (opcode >= 6'd32) && (opcode <= 6'd46);

`ifdef EX_STAGE_MULDIV_EN
  typedef enum logic [1:0] {IDLE, BUSY_MUL, BUSY_DIV} md_state_t;

  md_state_t   state, state_next;
  logic [4:0]  cnt;
  logic [31:0] hi, lo;
  logic [31:0] acc_hi, acc_lo, opnd_b;
  logic        neg_lo, neg_hi, div_zero;
  logic [31:0] acc_hi_n, acc_lo_n, hi_fin, lo_fin;
  logic [32:0] mul_sum, div_shift, div_diff;
  logic [63:0] prod_fin;
  logic        md_funct, issue_mul, issue_div, issue_signed;
  logic        a_neg, b_neg, done;
  logic [31:0] mag_a, mag_b;

  assign md_funct     = (opcode == 6'd0) &&
                        (((funct >= 6'd16) && (funct <= 6'd19)) ||
                         ((funct >= 6'd24) && (funct <= 6'd27)));
  assign stall_o      = (state != IDLE) && md_funct;
  assign issue_mul    = (state == IDLE) && (opcode == 6'd0) &&
                        ((funct == 6'd24) || (funct == 6'd25));
  assign issue_div    = (state == IDLE) && (opcode == 6'd0) &&
                        ((funct == 6'd26) || (funct == 6'd27));
  assign issue_signed = ~funct[0];
  assign a_neg        = issue_signed & rs_val[31];
  assign b_neg        = issue_signed & rt_val[31];
  assign mag_a        = a_neg ? -rs_val : rs_val;
  assign mag_b        = b_neg ? -rt_val : rt_val;
  assign done         = (state != IDLE) && (cnt == 5'd0);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (issue_mul)      state_next = BUSY_MUL;
        else if (issue_div) state_next = BUSY_DIV;
      end
      BUSY_MUL, BUSY_DIV: begin
        if (cnt == 5'd0) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // acc_hi holds the partial product / partial remainder, acc_lo the
  // multiplier / quotient; the final edge sign-corrects the updated values.
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_b} : 33'd0);
    div_shift = {acc_hi, acc_lo[31]};
    div_diff  = div_shift - {1'b0, opnd_b};
    acc_hi_n  = acc_hi;
    acc_lo_n  = acc_lo;
    if (state == BUSY_MUL) begin
      acc_hi_n = mul_sum[32:1];
      acc_lo_n = {mul_sum[0], acc_lo[31:1]};
    end else if (state == BUSY_DIV) begin
      acc_hi_n = div_diff[32] ? div_shift[31:0] : div_diff[31:0];
      acc_lo_n = {acc_lo[30:0], ~div_diff[32]};
    end
    prod_fin = neg_lo ? -{acc_hi_n, acc_lo_n} : {acc_hi_n, acc_lo_n};
    if (state == BUSY_DIV) begin
      // with a zero divisor the remainder path shifts out the dividend magnitude
      lo_fin = div_zero ? 32'hFFFF_FFFF : (neg_lo ? -acc_lo_n : acc_lo_n);
      hi_fin = neg_hi ? -acc_hi_n : acc_hi_n;
    end else begin
      lo_fin = prod_fin[31:0];
      hi_fin = prod_fin[63:32];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= 5'd0;
      hi       <= 32'd0;
      lo       <= 32'd0;
      acc_hi   <= 32'd0;
      acc_lo   <= 32'd0;
      opnd_b   <= 32'd0;
      neg_lo   <= 1'b0;
      neg_hi   <= 1'b0;
      div_zero <= 1'b0;
    end else if (issue_mul || issue_div) begin
      cnt      <= 5'd31;
      acc_hi   <= 32'd0;
      acc_lo   <= mag_a;
      opnd_b   <= mag_b;
      neg_lo   <= a_neg ^ b_neg;
      neg_hi   <= a_neg;
      div_zero <= (rt_val == 32'd0);
    end else if (state != IDLE) begin
      acc_hi <= acc_hi_n;
      acc_lo <= acc_lo_n;
      if (done) begin
        hi <= hi_fin;
        lo <= lo_fin;
      end else begin
        cnt <= cnt - 5'd1;
      end
    end else if ((opcode == 6'd0) && (funct == 6'd17)) begin
      hi <= rs_val;
    end else if ((opcode == 6'd0) && (funct == 6'd19)) begin
      lo <= rs_val;
    end
  end
`else
  assign stall_o = 1'b0;
`endif

  always_comb begin
    alu_res = 32'd0;
    rw_next = register_write;
    case (opcode)
      6'd0: begin
        case (funct)
          6'd0:         alu_res = rt_val << shamt;
          6'd2:         alu_res = rt_val >> shamt;
          6'd3:         alu_res = $signed(rt_val) >>> shamt;
          6'd4:         alu_res = rt_val << rs_val[4:0];
          6'd6:         alu_res = rt_val >> rs_val[4:0];
          6'd7:         alu_res = $signed(rt_val) >>> rs_val[4:0];
          6'd32, 6'd33: alu_res = rs_val + rt_val;
          6'd34, 6'd35: alu_res = rs_val - rt_val;
          6'd36:        alu_res = rs_val & rt_val;
          6'd37:        alu_res = rs_val | rt_val;
          6'd38:        alu_res = rs_val ^ rt_val;
          6'd39:        alu_res = ~(rs_val | rt_val);
          6'd42:        alu_res = {31'd0, $signed(rs_val) < $signed(rt_val)};
          6'd43:        alu_res = {31'd0, rs_val < rt_val};
`ifdef EX_STAGE_MULDIV_EN
          6'd16: begin
            alu_res = hi;
            rw_next = 1'b1;
          end
          6'd18: begin
            alu_res = lo;
            rw_next = 1'b1;
          end
          6'd17, 6'd19, 6'd24, 6'd25, 6'd26, 6'd27: rw_next = 1'b0;
`else
          6'd16, 6'd17, 6'd18, 6'd19,
          6'd24, 6'd25, 6'd26, 6'd27: rw_next = 1'b0;
`endif
          default: alu_res = 32'd0;
        endcase
      end
      6'd8, 6'd9: alu_res = rs_val + sext_imm;
      6'd10:      alu_res = {31'd0, $signed(rs_val) < $signed(sext_imm)};
      6'd11:      alu_res = {31'd0, rs_val < sext_imm};
      6'd12:      alu_res = rs_val & zext_imm;
      6'd13:      alu_res = rs_val | zext_imm;
      6'd14:      alu_res = rs_val ^ zext_imm;
      6'd15:      alu_res = {imm, 16'h0000};
      default: begin
        if (is_mem) alu_res = rt_val;
      end
    endcase
    addr_res = is_mem ? (rs_val + sext_imm) : alu_res;
  end

  // a stalled instruction stays on the inputs, so a bubble goes downstream
  always_ff @(posedge clk) begin
    if (reset || stall_o) begin
      opcode_o         <= 6'd0;
      rd_o             <= 5'd0;
      register_write_o <= 1'b0;
      result_o         <= 32'd0;
      address_o        <= 32'd0;
    end else begin
      opcode_o         <= opcode;
      rd_o             <= rd;
      register_write_o <= rw_next;
      result_o         <= alu_res;
      address_o        <= addr_res;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: arithmetic reference model checked every cycle, plus
// hand-computed literal expectations. Adapts to EX_STAGE_MULDIV_EN.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode, funct;
  logic [4:0]  shamt, rd;
  logic [15:0] imm;
  logic [31:0] rs_val, rt_val;
  logic        register_write;
  logic [5:0]  opcode_o;
  logic [4:0]  rd_o;
  logic        register_write_o;
  logic [31:0] result_o, address_o;
  logic        stall_o;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .shamt(shamt),
    .imm(imm), .rs_val(rs_val), .rt_val(rt_val), .rd(rd),
    .register_write(register_write), .opcode_o(opcode_o), .rd_o(rd_o),
    .register_write_o(register_write_o), .result_o(result_o),
    .address_o(address_o), .stall_o(stall_o)
  );

  int checks = 0;
  int errors = 0;
  bit model_ok = 1'b0;
  bit done_flag = 1'b0;
  bit last_stall = 1'b0;
  int n_stall;

  logic [5:0]  e_op;
  logic [4:0]  e_rd;
  logic        e_rw;
  logic [31:0] e_res, e_addr;
  int          busy_left = 0;
`ifdef EX_STAGE_MULDIV_EN
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0, p_hi = 32'd0, p_lo = 32'd0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit exp_stall();
`ifdef EX_STAGE_MULDIV_EN
    return (busy_left > 0) && (opcode == 6'd0) &&
           (((funct >= 6'd16) && (funct <= 6'd19)) || ((funct >= 6'd24) && (funct <= 6'd27)));
`else
    return 1'b0;
`endif
  endfunction

  // Reference: outputs from instruction semantics, HI/LO from native * / %,
  // and a busy window of 32 edges after each mult/div issue.
  always @(posedge clk) begin : model
    logic [31:0] se, r;
    logic w;
    bit st;
    logic signed [63:0] sp;
    logic [63:0] up;
    st = exp_stall();
    se = {{16{imm[15]}}, imm};
    r  = 32'd0;
    w  = register_write;
    if (reset) begin
      e_op = 0; e_rd = 0; e_rw = 0; e_res = 0; e_addr = 0; busy_left = 0;
`ifdef EX_STAGE_MULDIV_EN
      m_hi = 0; m_lo = 0;
`endif
    end else begin
`ifdef EX_STAGE_MULDIV_EN
      if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) begin m_hi = p_hi; m_lo = p_lo; end
      end
`endif
      if (st) begin
        e_op = 0; e_rd = 0; e_rw = 0; e_res = 0; e_addr = 0;
      end else begin
        if (opcode == 6'd0) begin
          case (funct)
            6'd0:  r = rt_val << shamt;
            6'd2:  r = rt_val >> shamt;
            6'd3:  r = $signed(rt_val) >>> shamt;
            6'd4:  r = rt_val << rs_val[4:0];
            6'd6:  r = rt_val >> rs_val[4:0];
            6'd7:  r = $signed(rt_val) >>> rs_val[4:0];
            6'd32, 6'd33: r = rs_val + rt_val;
            6'd34, 6'd35: r = rs_val - rt_val;
            6'd36: r = rs_val & rt_val;
            6'd37: r = rs_val | rt_val;
            6'd38: r = rs_val ^ rt_val;
            6'd39: r = ~(rs_val | rt_val);
            6'd42: r = ($signed(rs_val) < $signed(rt_val)) ? 32'd1 : 32'd0;
            6'd43: r = (rs_val < rt_val) ? 32'd1 : 32'd0;
`ifdef EX_STAGE_MULDIV_EN
            6'd16: begin r = m_hi; w = 1'b1; end
            6'd18: begin r = m_lo; w = 1'b1; end
            6'd17: begin m_hi = rs_val; w = 1'b0; end
            6'd19: begin m_lo = rs_val; w = 1'b0; end
            6'd24: begin
              sp = $signed(rs_val) * $signed(rt_val);
              p_hi = sp[63:32]; p_lo = sp[31:0]; busy_left = 32; w = 1'b0;
            end
            6'd25: begin
              up = rs_val * rt_val;
              p_hi = up[63:32]; p_lo = up[31:0]; busy_left = 32; w = 1'b0;
            end
            6'd26: begin
              if (rt_val == 0) begin p_lo = 32'hFFFFFFFF; p_hi = rs_val; end
              else if (rs_val == 32'h80000000 && rt_val == 32'hFFFFFFFF) begin
                p_lo = 32'h80000000; p_hi = 32'd0;
              end else begin
                p_lo = $signed(rs_val) / $signed(rt_val);
                p_hi = $signed(rs_val) % $signed(rt_val);
              end
              busy_left = 32; w = 1'b0;
            end
            6'd27: begin
              if (rt_val == 0) begin p_lo = 32'hFFFFFFFF; p_hi = rs_val; end
              else begin p_lo = rs_val / rt_val; p_hi = rs_val % rt_val; end
              busy_left = 32; w = 1'b0;
            end
`else
            6'd16, 6'd17, 6'd18, 6'd19, 6'd24, 6'd25, 6'd26, 6'd27: w = 1'b0;
`endif
            default: r = 32'd0;
          endcase
        end else begin
          case (opcode)
            6'd8, 6'd9: r = rs_val + se;
            6'd10: r = ($signed(rs_val) < $signed(se)) ? 32'd1 : 32'd0;
            6'd11: r = (rs_val < se) ? 32'd1 : 32'd0;
            6'd12: r = rs_val & {16'h0, imm};
            6'd13: r = rs_val | {16'h0, imm};
            6'd14: r = rs_val ^ {16'h0, imm};
            6'd15: r = {imm, 16'h0};
            default: r = (opcode >= 6'd32 && opcode <= 6'd46) ? rt_val : 32'd0;
          endcase
        end
        e_op = opcode; e_rd = rd; e_rw = w; e_res = r;
        e_addr = (opcode >= 6'd32 && opcode <= 6'd46) ? rs_val + se : r;
      end
    end
    model_ok = 1'b1;
  end

  always @(negedge clk) begin
    if (model_ok && !done_flag) begin
      chk("opcode_o", {26'd0, opcode_o}, {26'd0, e_op});
      chk("rd_o", {27'd0, rd_o}, {27'd0, e_rd});
      chk("register_write_o", {31'd0, register_write_o}, {31'd0, e_rw});
      chk("result_o", result_o, e_res);
      chk("address_o", address_o, e_addr);
      chk("stall_o", {31'd0, stall_o}, {31'd0, exp_stall()});
    end
  end

  task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                       input logic [15:0] im, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] d, input logic w);
    opcode = op; funct = fn; shamt = sh; imm = im;
    rs_val = a; rt_val = b; rd = d; register_write = w;
    #1 last_stall = stall_o;
    @(posedge clk);
    #2;
  endtask

  task automatic rop(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] sh);
    drive(6'd0, fn, sh, 16'h0, a, b, 5'd3, 1'b1);
  endtask

  task automatic iop(input logic [5:0] op, input logic [15:0] im, input logic [31:0] a);
    drive(op, 6'd0, 5'd0, im, a, 32'h0BAD_F00D, 5'd4, 1'b1);
  endtask

  // repeats an mfhi/mflo-style instruction until it is accepted
  task automatic md_read(input logic [5:0] fn, output int stalls);
    stalls = 0;
    drive(6'd0, fn, 5'd0, 16'h0, 32'h0, 32'h0, 5'd2, 1'b0);
    while (last_stall && stalls < 40) begin
      stalls++;
      drive(6'd0, fn, 5'd0, 16'h0, 32'h0, 32'h0, 5'd2, 1'b0);
    end
    if (last_stall) begin
      checks++; errors++;
      $display("FAIL md_read timeout: stall_o got 1 expected 0 after %0d cycles", stalls);
    end
  endtask

  initial begin
    reset = 1'b1;
    drive(6'd9, 6'd0, 5'd0, 16'h0001, 32'h5, 32'h0, 5'd7, 1'b1);
    chk("reset result_o", result_o, 32'd0);
    chk("reset rd_o", {27'd0, rd_o}, 32'd0);
    chk("reset register_write_o", {31'd0, register_write_o}, 32'd0);
    reset = 1'b0;

    drive(6'd9, 6'd0, 5'd0, 16'h0001, 32'hFFFFFFFF, 32'h0, 5'd5, 1'b1);
    chk("stall after reset", {31'd0, last_stall}, 32'd0);
    chk("addiu wrap result", result_o, 32'd0);
    chk("addiu register_write", {31'd0, register_write_o}, 32'd1);
    drive(6'd43, 6'd0, 5'd0, 16'hFFFC, 32'h1000, 32'hDEADBEEF, 5'd0, 1'b0);
    chk("sw address", address_o, 32'h00000FFC);
    chk("sw store data", result_o, 32'hDEADBEEF);

    rop(6'd33, 32'h7FFFFFFF, 32'h1, 5'd0);
    rop(6'd34, 32'h1, 32'h2, 5'd0);
    rop(6'd36, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0);
    rop(6'd37, 32'h0F0F0000, 32'h000000FF, 5'd0);
    rop(6'd38, 32'hAAAA5555, 32'hFFFF0000, 5'd0);
    rop(6'd39, 32'h0, 32'h0, 5'd0);
    chk("nor zero", result_o, 32'hFFFFFFFF);
    rop(6'd42, 32'hFFFFFFFF, 32'h1, 5'd0);
    chk("slt signed", result_o, 32'd1);
    rop(6'd43, 32'hFFFFFFFF, 32'h1, 5'd0);
    chk("sltu unsigned", result_o, 32'd0);
    rop(6'd0, 32'h0, 32'h00000003, 5'd31);
    rop(6'd2, 32'h0, 32'h80000000, 5'd31);
    rop(6'd3, 32'h0, 32'h80000000, 5'd4);
    chk("sra sign fill", result_o, 32'hF8000000);
    rop(6'd4, 32'h24, 32'h1, 5'd0);
    rop(6'd6, 32'h21, 32'hF0000000, 5'd0);
    rop(6'd7, 32'h1F, 32'h80000000, 5'd0);
    rop(6'd1, 32'h5, 32'h6, 5'd0);
    chk("unlisted funct result", result_o, 32'd0);
    chk("unlisted funct rw", {31'd0, register_write_o}, 32'd1);
    iop(6'd10, 16'hFFFF, 32'hFFFFFFFE);
    iop(6'd11, 16'hFFFF, 32'h7FFFFFFF);
    iop(6'd12, 16'h8001, 32'hFFFFFFFF);
    iop(6'd13, 16'h8000, 32'h00000001);
    iop(6'd14, 16'hFFFF, 32'h12345678);
    iop(6'd15, 16'h1234, 32'h0);
    chk("lui", result_o, 32'h12340000);
    iop(6'd35, 16'h0010, 32'h2000);
    iop(6'd2, 16'h0010, 32'h2000);

`ifdef EX_STAGE_MULDIV_EN
    drive(6'd0, 6'd24, 5'd0, 16'h0, 32'd7, 32'hFFFFFFFD, 5'd0, 1'b1);
    chk("mult issue rw", {31'd0, register_write_o}, 32'd0);
    md_read(6'd18, n_stall);
    chk("mult stall cycles", n_stall, 32'd32);
    chk("mult lo", result_o, 32'hFFFFFFEB);
    chk("mflo rw forced", {31'd0, register_write_o}, 32'd1);
    md_read(6'd16, n_stall);
    chk("mult hi", result_o, 32'hFFFFFFFF);

    drive(6'd0, 6'd26, 5'd0, 16'h0, 32'hFFFFFFF9, 32'd2, 5'd0, 1'b0);
    rop(6'd33, 32'd10, 32'd20, 5'd0);
    chk("independent while busy stall", {31'd0, last_stall}, 32'd0);
    chk("independent while busy result", result_o, 32'd30);
    md_read(6'd18, n_stall);
    chk("div lo", result_o, 32'hFFFFFFFD);
    md_read(6'd16, n_stall);
    chk("div hi", result_o, 32'hFFFFFFFF);

    drive(6'd0, 6'd27, 5'd0, 16'h0, 32'd5, 32'd0, 5'd0, 1'b0);
    md_read(6'd18, n_stall);
    chk("divu by zero lo", result_o, 32'hFFFFFFFF);
    md_read(6'd16, n_stall);
    chk("divu by zero hi", result_o, 32'd5);

    drive(6'd0, 6'd26, 5'd0, 16'h0, 32'h80000000, 32'hFFFFFFFF, 5'd0, 1'b0);
    md_read(6'd18, n_stall);
    chk("div overflow lo", result_o, 32'h80000000);
    md_read(6'd16, n_stall);
    chk("div overflow hi", result_o, 32'd0);

    drive(6'd0, 6'd25, 5'd0, 16'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0, 1'b0);
    md_read(6'd16, n_stall);
    chk("multu hi", result_o, 32'hFFFFFFFE);
    md_read(6'd18, n_stall);
    chk("multu lo", result_o, 32'd1);

    drive(6'd0, 6'd17, 5'd0, 16'h0, 32'h1234, 32'h0, 5'd6, 1'b1);
    chk("mthi rw", {31'd0, register_write_o}, 32'd0);
    drive(6'd0, 6'd19, 5'd0, 16'h0, 32'h5678, 32'h0, 5'd6, 1'b1);
    md_read(6'd16, n_stall);
    chk("mthi readback", result_o, 32'h1234);
    md_read(6'd18, n_stall);
    chk("mtlo readback", result_o, 32'h5678);

    drive(6'd0, 6'd25, 5'd0, 16'h0, 32'd3, 32'd4, 5'd0, 1'b0);
    for (int i = 0; i < 9; i++) rop(6'd0, 32'h0, i, 5'd1);
    reset = 1'b1;
    rop(6'd0, 32'h0, 32'h1, 5'd1);
    reset = 1'b0;
    drive(6'd0, 6'd16, 5'd0, 16'h0, 32'h0, 32'h0, 5'd2, 1'b0);
    chk("abort stall", {31'd0, last_stall}, 32'd0);
    chk("abort hi", result_o, 32'd0);
`else
    drive(6'd0, 6'd24, 5'd0, 16'h0, 32'd7, 32'hFFFFFFFD, 5'd1, 1'b1);
    chk("no-muldiv mult stall", {31'd0, last_stall}, 32'd0);
    chk("no-muldiv mult rw", {31'd0, register_write_o}, 32'd0);
    drive(6'd0, 6'd18, 5'd0, 16'h0, 32'd0, 32'd0, 5'd2, 1'b1);
    chk("no-muldiv mflo stall", {31'd0, last_stall}, 32'd0);
    chk("no-muldiv mflo rw", {31'd0, register_write_o}, 32'd0);
    chk("no-muldiv mflo result", result_o, 32'd0);
    drive(6'd0, 6'd17, 5'd0, 16'h0, 32'h55, 32'd0, 5'd2, 1'b1);
    drive(6'd0, 6'd16, 5'd0, 16'h0, 32'd0, 32'd0, 5'd2, 1'b1);
    chk("no-muldiv mfhi result", result_o, 32'd0);
`endif

    rop(6'd35, 32'd100, 32'd1, 5'd0);
    chk("final subu", result_o, 32'd99);
    @(negedge clk);
    done_flag = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 The block SHALL have these ports, clock and reset first:
 clk  in  1  single clock; all state updates on rising edge.
 reset  in  1  reset is synchronous and active-high.
 opcode  in  6  instruction opcode.
 funct  in  6  R-type function field.
 shamt  in  5  shift amount.
 imm  in  16  immediate field.
 rs_val  in  32  rs operand value.
 rt_val  in  32  rt operand value.
 rd  in  5  destination register index.
 register_write  in  1  instruction writes a GPR.
 opcode_o  out  6  registered opcode to MEM.
 rd_o  out  5  registered destination.
 register_write_o  out  1  registered GPR write enable.
 result_o  out  32  ALU result, or store data for memory opcodes.
 address_o  out  32  effective memory address.
 stall_o  out  1  combinational; upstream SHALL hold its inputs while high.

Function
REQ-002 Outputs SHALL register inputs with 1-cycle latency when stall_o=0.
REQ-003 R-type (opcode 0) results SHALL be: add/addu(32/33)=rs+rt mod 2^32; sub/subu(34/35)=rs-rt; and(36), or(37), xor(38), nor(39); slt(42) signed, sltu(43) unsigned, giving 0/1.
REQ-004 Shifts SHALL be: sll(0), srl(2), sra(3) by shamt; sllv(4), srlv(6), srav(7) by rs_val[4:0]. There SHALL be no overflow traps.
REQ-005 I-type results SHALL be: addi/addiu(8/9)=rs+sext(imm); slti(10) signed compare, sltiu(11) unsigned compare, both against sext(imm); andi(12), ori(13), xori(14) with zext(imm); lui(15)={imm,16'h0}.
REQ-006 Opcodes 32-46: address_o SHALL be rs_val+sext(imm) and result_o SHALL be rt_val.
REQ-007 Non-memory opcodes SHALL drive address_o=result_o.
REQ-008 Unlisted opcodes/functs SHALL give result_o=0 and pass register_write through unchanged.
REQ-009 The HI/LO unit SHALL be an FSM with states IDLE, BUSY_MUL, BUSY_DIV and a 5-bit iteration counter.
REQ-010 In IDLE, mult(24)/multu(25) SHALL capture operands and enter BUSY_MUL; div(26)/divu(27) SHALL enter BUSY_DIV.
REQ-011 Each busy state SHALL run exactly 32 iterations: shift-add for multiply, restoring division for divide.
REQ-012 On the 32nd busy edge the unit SHALL write HI/LO and return to IDLE.
REQ-013 Signed operations SHALL use magnitudes with sign correction: quotient truncates toward zero; remainder takes the dividend's sign.
REQ-014 Divide by zero SHALL give LO=32'hFFFFFFFF, HI=dividend. Signed 0x80000000/-1 SHALL give LO=0x80000000, HI=0.
REQ-015 mfhi(16)/mflo(18) SHALL return HI/LO with register_write forced to 1. mthi(17)/mtlo(19) SHALL load rs_val, register_write_o=0.
REQ-016 mult/div issue SHALL forward register_write_o=0.
REQ-017 stall_o SHALL be 1 iff FSM is not IDLE and the current instruction is funct 16-19 or 24-27; otherwise it SHALL be 0.
REQ-018 While stall_o=1, outputs SHALL be a bubble: opcode_o=0, register_write_o=0, rd_o=0, result_o=0, address_o=0.
REQ-019 Independent instructions SHALL proceed while the FSM is busy.
REQ-020 A dependent instruction arriving on the completion edge SHALL see stall_o=0 on the next cycle and read the new HI/LO.

Reset
REQ-021 With reset=1 at an edge, all outputs, HI, LO and the counter SHALL be 0 and the FSM SHALL be IDLE.
REQ-022 Reset mid-operation SHALL abort any multiply/divide with no HI/LO update.
REQ-023 stall_o SHALL be 0 in the cycle after reset.

Configuration
REQ-024 With macro EX_STAGE_MULDIV_EN defined, REQ-009..REQ-020 SHALL be implemented.
REQ-025 Without EX_STAGE_MULDIV_EN: funct 16-19 and 24-27 SHALL give result_o=0 and register_write_o=0; no HI/LO/FSM logic SHALL exist; stall_o SHALL be tied to 0.

Verification
REQ-026 addiu rs=0xFFFFFFFF imm=0x0001 -> result_o=0 next cycle, register_write_o=1.
REQ-027 sw (43) rs=0x1000 imm=0xFFFC rt=0xDEADBEEF -> address_o=0x0FFC, result_o=0xDEADBEEF.
REQ-028 mult 7 x -3, then mflo -> stall_o high until the completion edge, then result_o=0xFFFFFFEB; mfhi -> 0xFFFFFFFF.
REQ-029 div -7/2 then mflo, mfhi -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu 5/0 -> LO=0xFFFFFFFF, HI=5.
REQ-030 multu issued, reset asserted at busy cycle 10, then mfhi -> result_o=0, stall_o=0.
REQ-031 Build without EX_STAGE_MULDIV_EN, issue mult then mflo -> stall_o never asserts, register_write_o=0, result_o=0.
